// File: rtl/shift_right_seq_pkg.sv
// Shared definitions for the iterative right shifter.
//   - Op encodings for rotate / logical / arithmetic right shift
//   - Controller state encodings (2 bits, one code unused)
//   - fill_bit(): selects the bit that enters the MSB on each 1-bit step
package shift_right_seq_pkg;

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Rotate recirculates the LSB, arithmetic replicates the sign bit,
  // logical (and the spare 2'b11 code) shifts in zero.
  function automatic logic fill_bit(input logic [1:0] op,
                                    input logic       msb,
                                    input logic       lsb);
    logic f;
    f = 1'b0;
    case (op)
      OP_ROR:  f = lsb;
      OP_SRA:  f = msb;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/shift_right_seq_cells.sv
// Basic library cells used by the shifter datapath and controller.
//   dff    : W-bit register, synchronous active-high reset to RST_VAL
//            ports: clk, rst, d[W-1:0] -> q[W-1:0]
//   mux2_1 : 1-bit 2:1 multiplexer
//            ports: a (sel=0), b (sel=1), sel -> y
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/shift_right_seq_shift_right1.sv
// Combinational single-position right shift stage built from mux2_1 cells.
//   In[WIDTH-1:0] : operand
//   Fill          : bit entering the MSB when shifting
//   Cnt           : 1 = shift right by one, 0 = pass through
//   Out[WIDTH-1:0]: result
module shift_right1 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] In,
  input  logic             Fill,
  input  logic             Cnt,
  output logic [WIDTH-1:0] Out
);

  genvar i;
  generate
    for (i = 0; i < WIDTH - 1; i++) begin : g_bit
      mux2_1 u_mux (
        .a   (In[i]),
        .b   (In[i+1]),
        .sel (Cnt),
        .y   (Out[i])
      );
    end
  endgenerate

  mux2_1 u_mux_msb (
    .a   (In[WIDTH-1]),
    .b   (Fill),
    .sel (Cnt),
    .y   (Out[WIDTH-1])
  );

endmodule

// File: rtl/shift_right_seq.sv
// Iterative right shifter / rotator. One operand is accepted on a start
// handshake, then a single 1-bit right stage is applied once per clock
// for Cnt cycles. done pulses for one cycle when Out holds the result.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, honoured only in IDLE or DONE
//   In    : operand, captured on the accepting edge
//   Cnt   : shift amount, captured on the accepting edge
//   Op    : 00 ROR, 01 SRL, 10 SRA, 11 SRL
//   Out   : result register, held until the next accept
//   busy  : high while shifting
//   done  : one-cycle completion pulse
import shift_right_seq_pkg::*;

module shift_right_seq #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNTW-1:0]  Cnt,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] Out,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNTW-1:0]  rem_q;
  logic [CNTW-1:0]  rem_d;
  logic [1:0]       op_q;
  logic [1:0]       op_d;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] shifted;
  logic             fill;

  // Registers: state, remaining count, latched op, result
  dff #(.W(2), .RST_VAL(2'b00)) u_state (
    .clk (clk), .rst (rst), .d (state_d), .q (state_q)
  );

  dff #(.W(CNTW), .RST_VAL('0)) u_rem (
    .clk (clk), .rst (rst), .d (rem_d), .q (rem_q)
  );

  dff #(.W(2), .RST_VAL(2'b00)) u_op (
    .clk (clk), .rst (rst), .d (op_d), .q (op_q)
  );

  dff #(.W(WIDTH), .RST_VAL('0)) u_out (
    .clk (clk), .rst (rst), .d (out_d), .q (Out)
  );

  // Single shared 1-bit stage; always enabled, its output is only
  // selected while in SHIFT.
  assign fill = fill_bit(op_q, Out[WIDTH-1], Out[0]);

  shift_right1 #(.WIDTH(WIDTH)) u_stage (
    .In   (Out),
    .Fill (fill),
    .Cnt  (1'b1),
    .Out  (shifted)
  );

  // Next-state and register-load logic
  always_comb begin
    state_d = ST_IDLE;
    rem_d   = rem_q;
    op_d    = op_q;
    out_d   = Out;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          out_d   = In;
          rem_d   = Cnt;
          op_d    = Op;
          state_d = (Cnt == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        out_d = shifted;
        rem_d = rem_q - CNTW'(1);
        // <= 1 rather than == 1 so a corrupted zero count cannot spin
        // through a full wrap-around.
        state_d = (rem_q <= CNTW'(1)) ? ST_DONE : ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule
